// File: rtl/uart_packet_pkg.sv
// Shared packet geometry and decoder state encoding for uart_packet_decoder.
// UART_PACKET_CHECKSUM_EN adds a trailing mod-256 checksum byte to each packet.
package uart_packet_pkg;

`ifdef UART_PACKET_CHECKSUM_EN
  localparam int unsigned PKT_BYTES = 9;
`else
  localparam int unsigned PKT_BYTES = 8;
`endif
  localparam int unsigned PKT_ADDR_BYTES = 4;
  localparam int unsigned PKT_DATA_BYTES = 4;
  localparam int unsigned PAYLOAD_BYTES  = PKT_ADDR_BYTES + PKT_DATA_BYTES;
  localparam int unsigned CNT_W          = $clog2(PKT_BYTES);

  typedef enum logic [1:0] {
    ST_RECV,
    ST_EMIT,
    ST_ABORT
  } state_e;

`ifdef UART_PACKET_CHECKSUM_EN
  function automatic logic [7:0] byte_sum(input logic [PAYLOAD_BYTES*8-1:0] p);
    logic [7:0] s;
    s = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      s = s + p[i*8 +: 8];
    end
    return s;
  endfunction
`endif

endpackage

// File: rtl/uart_packet_decoder_timer.sv
// Inter-byte idle timer: counts while run is high, expired flags the cycle
// in which the count reaches TIMEOUT_CYCLES.
module uart_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 8680
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + TW'(1);
    end
  end

  // Asserted in the cycle whose increment would bring the count to the limit.
  assign expired = run && (count_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_packet_decoder.sv
// Assembles little-endian address/data packets from a UART byte stream.
// UART_PACKET_CHECKSUM_EN: 9-byte packets, last byte is the mod-256 payload sum.
module uart_packet_decoder
  import uart_packet_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8680
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [31:0] rx_addr,
  output logic [31:0] rx_data,
  output logic        rx_we,
  output logic        frame_err
);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PAYLOAD_BYTES*8-1:0] shadow_q, shadow_d;
  logic [31:0]                addr_q, addr_d;
  logic [31:0]                data_q, data_d;
  logic                       last_byte;
  logic                       sum_ok;
  logic                       timer_clear;
  logic                       timer_run;
  logic                       timer_expired;

  uart_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .run    (timer_run),
    .expired(timer_expired)
  );

  always_comb begin
    state_d     = ST_RECV;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    addr_d      = addr_q;
    data_d      = data_q;
    last_byte   = (cnt_q == CNT_W'(PKT_BYTES - 1));
    sum_ok      = 1'b1;
    timer_run   = (cnt_q != '0);
    timer_clear = rx_byte_valid || timer_expired;
`ifdef UART_PACKET_CHECKSUM_EN
    sum_ok      = (rx_byte == byte_sum(shadow_q));
`endif

    if (rx_byte_valid) begin
      for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          shadow_d[i*8 +: 8] = rx_byte;
        end
      end
      if (last_byte) begin
        cnt_d = '0;
        // Outputs load from shadow_d so the final payload byte lands this cycle.
        if (sum_ok) begin
          state_d = ST_EMIT;
          addr_d  = shadow_d[PKT_ADDR_BYTES*8-1:0];
          data_d  = shadow_d[PAYLOAD_BYTES*8-1:PKT_ADDR_BYTES*8];
        end else begin
          state_d = ST_ABORT;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (timer_expired) begin
      cnt_d   = '0;
      state_d = ST_ABORT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RECV;
      cnt_q    <= '0;
      shadow_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign rx_we     = (state_q == ST_EMIT);
  assign frame_err = (state_q == ST_ABORT);
  assign rx_addr   = addr_q;
  assign rx_data   = data_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Randomized bench for uart_packet_decoder against a queue-based packet model,
// plus directed scenarios with literal expectations.
module tb_uart_packet_decoder;

  localparam int unsigned T = 20;
`ifdef UART_PACKET_CHECKSUM_EN
  localparam int unsigned PKT = 9;
`else
  localparam int unsigned PKT = 8;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_byte_valid = 1'b0;
  logic [31:0] rx_addr;
  logic [31:0] rx_data;
  logic        rx_we;
  logic        frame_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit          chk_en = 1'b0;

  uart_packet_decoder #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .rx_addr      (rx_addr),
    .rx_data      (rx_data),
    .rx_we        (rx_we),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  int unsigned m_idle = 0;
  logic        m_we = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;

  function automatic bit pkt_ok(input logic [7:0] q[$]);
`ifdef UART_PACKET_CHECKSUM_EN
    int unsigned s = 0;
    for (int i = 0; i < 8; i++) s += q[i];
    return (s % 256) == q[8];
`else
    return (q.size() == 8);
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_idle <= 0;
      m_we   <= 1'b0;
      m_err  <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
    end else begin
      m_we  <= 1'b0;
      m_err <= 1'b0;
      if (rx_byte_valid) begin
        mq.push_back(rx_byte);
        m_idle <= 0;
        if (mq.size() == PKT) begin
          if (pkt_ok(mq)) begin
            m_we   <= 1'b1;
            m_addr <= {mq[3], mq[2], mq[1], mq[0]};
            m_data <= {mq[7], mq[6], mq[5], mq[4]};
          end else begin
            m_err <= 1'b1;
          end
          mq.delete();
        end
      end else if (mq.size() != 0) begin
        if (m_idle + 1 == T) begin
          m_err  <= 1'b1;
          m_idle <= 0;
          mq.delete();
        end else begin
          m_idle <= m_idle + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_we", {31'd0, rx_we}, {31'd0, m_we});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_err});
      check("rx_addr", rx_addr, m_addr);
      check("rx_data", rx_data, m_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit v, input logic [7:0] b);
    @(negedge clk);
    rx_byte_valid = v;
    rx_byte       = b;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  function automatic void build(input logic [31:0] a, input logic [31:0] d, input bit bad,
                                output logic [7:0] p[9]);
    logic [7:0] s = '0;
    for (int i = 0; i < 4; i++) begin
      p[i]     = a[8*i +: 8];
      p[i + 4] = d[8*i +: 8];
    end
    for (int i = 0; i < 8; i++) s = s + p[i];
    p[8] = bad ? s + 8'($urandom_range(1, 255)) : s;
  endfunction

  task automatic send_bytes(input logic [7:0] p[9], input int lo, input int hi);
    for (int i = lo; i < hi; i++) cyc(1'b1, p[i]);
  endtask

  task automatic expect_out(input string name, input bit we, input bit err,
                            input logic [31:0] a, input logic [31:0] d);
    check({name, ".we"}, {31'd0, rx_we}, {31'd0, we});
    check({name, ".err"}, {31'd0, frame_err}, {31'd0, err});
    check({name, ".addr"}, rx_addr, a);
    check({name, ".data"}, rx_data, d);
  endtask

  task automatic pulse_reset();
    rx_byte_valid = 1'b0;
    #2 reset = 1'b0;
    #1 expect_out("async_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] pa[9];
  logic [7:0] pb[9];

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset_state", 1'b0, 1'b0, 32'h0, 32'h0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Basic packet: 78 56 34 12 EF BE AD DE
    build(32'h12345678, 32'hDEADBEEF, 1'b0, pa);
    send_bytes(pa, 0, PKT);
    cyc(1'b0, 8'h00);
    expect_out("pkt_basic", 1'b1, 1'b0, 32'h12345678, 32'hDEADBEEF);
    cyc(1'b0, 8'h00);
    expect_out("pkt_hold", 1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF);

    // Partial packet timed out
    cyc(1'b1, 8'hAA); cyc(1'b1, 8'hBB); cyc(1'b1, 8'hCC);
    idle(T);
    expect_out("timeout_pre", 1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF);
    cyc(1'b0, 8'h00);
    expect_out("timeout_err", 1'b0, 1'b1, 32'h12345678, 32'hDEADBEEF);
    build(32'h1, 32'h2, 1'b0, pa);
    send_bytes(pa, 0, PKT);
    cyc(1'b0, 8'h00);
    expect_out("after_timeout", 1'b1, 1'b0, 32'h1, 32'h2);

    // Back-to-back: byte 0 of B lands in A's rx_we cycle
    build(32'hA5A5_0001, 32'h0BAD_F00D, 1'b0, pa);
    build(32'h7654_3210, 32'hCAFE_0042, 1'b0, pb);
    send_bytes(pa, 0, PKT);
    cyc(1'b1, pb[0]);
    expect_out("b2b_first", 1'b1, 1'b0, 32'hA5A5_0001, 32'h0BAD_F00D);
    send_bytes(pb, 1, PKT);
    cyc(1'b0, 8'h00);
    expect_out("b2b_second", 1'b1, 1'b0, 32'h7654_3210, 32'hCAFE_0042);

    // Reset after byte 5
    build(32'h1111_2222, 32'h3333_4444, 1'b0, pa);
    send_bytes(pa, 0, 6);
    cyc(1'b0, 8'h00);
    pulse_reset();
    build(32'h0102_0304, 32'h0506_0708, 1'b0, pa);
    send_bytes(pa, 0, PKT);
    cyc(1'b0, 8'h00);
    expect_out("after_reset", 1'b1, 1'b0, 32'h0102_0304, 32'h0506_0708);

    // Byte arriving exactly on the expiry cycle is accepted
    build(32'hFEED_0003, 32'h0000_BEEF, 1'b0, pa);
    send_bytes(pa, 0, 3);
    idle(T - 1);
    send_bytes(pa, 3, PKT);
    cyc(1'b0, 8'h00);
    expect_out("expiry_edge", 1'b1, 1'b0, 32'hFEED_0003, 32'h0000_BEEF);

`ifdef UART_PACKET_CHECKSUM_EN
    build(32'h1, 32'h2, 1'b0, pa);
    check("cksum_byte", {24'd0, pa[8]}, 32'h03);
    send_bytes(pa, 0, PKT);
    cyc(1'b0, 8'h00);
    expect_out("cksum_good", 1'b1, 1'b0, 32'h1, 32'h2);
    pa[8] = 8'h04;
    send_bytes(pa, 0, PKT);
    cyc(1'b0, 8'h00);
    expect_out("cksum_bad", 1'b0, 1'b1, 32'h1, 32'h2);
    build(32'h5, 32'h6, 1'b1, pa);
    send_bytes(pa, 0, PKT);
    cyc(1'b0, 8'h00);
    expect_out("cksum_bad2", 1'b0, 1'b1, 32'h1, 32'h2);
`endif

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        build($urandom, $urandom, 1'b0, pa);
        send_bytes(pa, 0, int'($urandom_range(1, PKT - 1)));
        cyc(1'b0, 8'h00);
        pulse_reset();
      end else begin
        build($urandom, $urandom, ($urandom_range(0, 5) == 0), pa);
        for (int i = 0; i < int'(PKT); i++) begin
          cyc(1'b1, pa[i]);
          if (i < int'(PKT) - 1) begin
            int unsigned sel;
            int unsigned g;
            sel = $urandom_range(0, 39);
            if (sel < 30)       g = 0;
            else if (sel < 36)  g = $urandom_range(1, 3);
            else if (sel == 36) g = T - 1;
            else if (sel == 37) g = T;
            else if (sel == 38) g = T + 1;
            else                g = 0;
            idle(g);
          end
        end
        idle($urandom_range(0, 2));
      end
    end

    idle(T + 5);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
